// File: rtl/mem_checker_pkg.sv
// Shared types and constants for the memory-write checker: state and fail-code
// encodings plus the entry-count limit that sizes the match counter.
package mem_checker_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_DATA    = 2'd1,
    FC_TIMEOUT = 2'd2
  } fail_code_t;

  localparam int MAX_EXP = 16;
  // Wide enough to hold every count from 0 up to MAX_EXP inclusive.
  localparam int MATCH_W = $clog2(MAX_EXP + 1);

endpackage

// File: rtl/exp_entry_match.sv
// Combinational compare of one snooped write against one expected entry.
// hit: data matches (and address too when addresses are checked).
// conflict: address matches but data differs; impossible when addresses are ignored.
module exp_entry_match #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int ADDR_CHK = 1
) (
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              hit,
  output logic              conflict
);

  logic addr_eq;
  logic data_eq;

  assign addr_eq = (dataadr == exp_addr);
  assign data_eq = (writedata == exp_data);

  // Address equality only qualifies a hit or a conflict when address checking is on.
  always_comb begin
    hit      = data_eq & (addr_eq | (ADDR_CHK == 0));
    conflict = (ADDR_CHK != 0) & addr_eq & ~data_eq;
  end

endmodule

// File: rtl/mem_write_checker.sv
// Pass/fail monitor that snoops a CPU data-memory write port and compares the
// writes against NUM_EXP expected address/data pairs, in order or in any order,
// with a cycle-count timeout. All status outputs come from registers.
// Optional build macro: MEM_WRITE_CHECKER_IRQ_STIM_EN adds the interrupts output
// that pulses IRQ_MASK for IRQ_LEN cycles starting at cycle IRQ_AT while running.
module mem_write_checker
  import mem_checker_pkg::*;
#(
  parameter int                      DATA_W   = 32,
  parameter int                      ADDR_W   = 32,
  parameter int                      NUM_EXP  = 4,
  parameter logic [NUM_EXP*DATA_W-1:0] EXP_DATA = '0,
  parameter logic [NUM_EXP*ADDR_W-1:0] EXP_ADDR = '0,
  parameter int                      ADDR_CHK = 1,
  parameter int                      ORDERED  = 1,
  parameter int                      TIMEOUT  = 5000,
  parameter int                      CNT_W    = 32
`ifdef MEM_WRITE_CHECKER_IRQ_STIM_EN
  , parameter int                    NUM_IRQ  = 8
  , parameter logic [NUM_IRQ-1:0]    IRQ_MASK = '0
  , parameter logic [CNT_W-1:0]      IRQ_AT   = CNT_W'(100)
  , parameter int                    IRQ_LEN  = 5
`endif
) (
  input  logic               ph1,
  input  logic               reset,
  input  logic               memwrite,
  input  logic [ADDR_W-1:0]  dataadr,
  input  logic [DATA_W-1:0]  writedata,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic [1:0]         fail_code,
  output logic [MATCH_W-1:0] match_cnt,
  output logic [CNT_W-1:0]   end_cycle
`ifdef MEM_WRITE_CHECKER_IRQ_STIM_EN
  , output logic [NUM_IRQ-1:0] interrupts
`endif
);

  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [MATCH_W-1:0] MATCH_ALL = MATCH_W'(NUM_EXP);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cycle_reg, cycle_next;
  logic [NUM_EXP-1:0]   hit_mask_reg, hit_mask_next;
  logic [MATCH_W-1:0]   match_cnt_reg, match_cnt_next;
  fail_code_t           fail_code_reg, fail_code_next;
  logic [CNT_W-1:0]     end_cycle_reg, end_cycle_next;

  logic [NUM_EXP-1:0]   hit_vec;
  logic [NUM_EXP-1:0]   conf_vec;
  logic [NUM_EXP-1:0]   cand;
  logic [NUM_EXP-1:0]   avail;
  logic [NUM_EXP-1:0]   first_hit;
  logic                 any_hit;
  logic                 conflict;

  // One comparator per expected entry. An entry is a candidate only while it is
  // still unhit; in ordered mode it must additionally be the next one in line,
  // and since hits happen strictly in order the match count doubles as the index.
  for (genvar gi = 0; gi < NUM_EXP; gi++) begin : g_entry
    exp_entry_match #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ADDR_CHK(ADDR_CHK)
    ) u_match (
      .dataadr  (dataadr),
      .writedata(writedata),
      .exp_addr (EXP_ADDR[gi*ADDR_W +: ADDR_W]),
      .exp_data (EXP_DATA[gi*DATA_W +: DATA_W]),
      .hit      (hit_vec[gi]),
      .conflict (conf_vec[gi])
    );

    assign cand[gi] = ~hit_mask_reg[gi] &
                      ((ORDERED == 0) || (match_cnt_reg == MATCH_W'(gi)));
  end

  // Reduce candidate compares: claim the lowest-index hit; a conflict only
  // counts when no candidate entry was hit by the same write.
  always_comb begin
    avail     = hit_vec & cand;
    first_hit = avail & (~avail + NUM_EXP'(1));
    any_hit   = |avail;
    conflict  = (|(conf_vec & cand)) & ~any_hit;
  end

  // Next-state logic: PASS has priority over a same-cycle timeout.
  always_comb begin
    state_next     = state_reg;
    cycle_next     = cycle_reg;
    hit_mask_next  = hit_mask_reg;
    match_cnt_next = match_cnt_reg;
    fail_code_next = fail_code_reg;
    end_cycle_next = end_cycle_reg;
    case (state_reg)
      RUN: begin
        if (cycle_reg != '1) begin
          cycle_next = cycle_reg + CNT_W'(1);
        end
        if (memwrite && any_hit) begin
          hit_mask_next  = hit_mask_reg | first_hit;
          match_cnt_next = match_cnt_reg + MATCH_W'(1);
        end
        if (match_cnt_next == MATCH_ALL) begin
          state_next     = PASS;
          end_cycle_next = cycle_reg;
        end else if (memwrite && conflict) begin
          state_next     = FAIL;
          fail_code_next = FC_DATA;
          end_cycle_next = cycle_reg;
        end else if (cycle_reg == TO_LAST) begin
          state_next     = FAIL;
          fail_code_next = FC_TIMEOUT;
          end_cycle_next = cycle_reg;
        end
      end
      PASS, FAIL: begin
        state_next = state_reg;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // State and status registers; reset clears everything, even from PASS/FAIL.
  always_ff @(posedge ph1) begin
    if (reset) begin
      state_reg     <= RUN;
      cycle_reg     <= '0;
      hit_mask_reg  <= '0;
      match_cnt_reg <= '0;
      fail_code_reg <= FC_NONE;
      end_cycle_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cycle_reg     <= cycle_next;
      hit_mask_reg  <= hit_mask_next;
      match_cnt_reg <= match_cnt_next;
      fail_code_reg <= fail_code_next;
      end_cycle_reg <= end_cycle_next;
    end
  end

  assign done      = (state_reg != RUN);
  assign pass      = (state_reg == PASS);
  assign fail      = (state_reg == FAIL);
  assign fail_code = fail_code_reg;
  assign match_cnt = match_cnt_reg;
  assign end_cycle = end_cycle_reg;

`ifdef MEM_WRITE_CHECKER_IRQ_STIM_EN
  logic [NUM_IRQ-1:0] interrupts_reg, interrupts_next;
  logic [CNT_W:0]     win_end;
  logic               in_win;

  // Window is evaluated on the upcoming cycle value so the registered output
  // lines up with the cycle count it describes; one extra bit avoids wrap.
  always_comb begin
    win_end         = {1'b0, IRQ_AT} + (CNT_W+1)'(IRQ_LEN);
    in_win          = (cycle_next >= IRQ_AT) && ({1'b0, cycle_next} < win_end);
    interrupts_next = (state_next == RUN && in_win) ? IRQ_MASK : '0;
  end

  // Interrupt stimulus register, cleared by reset.
  always_ff @(posedge ph1) begin
    if (reset) begin
      interrupts_reg <= '0;
    end else begin
      interrupts_reg <= interrupts_next;
    end
  end

  assign interrupts = interrupts_reg;
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Self-checking bench for mem_write_checker. Three instances with different
// configurations: A (single entry, data-only match), B (ordered, 2 entries,
// TIMEOUT=50) and C (unordered, 3 entries). Build with
// MEM_WRITE_CHECKER_IRQ_STIM_EN to also check the interrupt stimulus on A.
module tb_mem_write_checker;

  logic        ph1;
  logic        rst_s [3];
  logic        mw_s  [3];
  logic [31:0] adr_s [3];
  logic [31:0] dat_s [3];
  logic        done_s [3];
  logic        pass_s [3];
  logic        fail_s [3];
  logic [1:0]  code_s [3];
  logic [4:0]  cnt_s  [3];
  logic [31:0] end_s  [3];
`ifdef MEM_WRITE_CHECKER_IRQ_STIM_EN
  logic [7:0]  irq_a;
`endif

  int checks;
  int failures;

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  mem_write_checker #(
    .NUM_EXP (1),
    .EXP_DATA(32'd2201),
    .EXP_ADDR(32'd0),
    .ADDR_CHK(0),
    .ORDERED (1),
    .TIMEOUT (5000)
`ifdef MEM_WRITE_CHECKER_IRQ_STIM_EN
    , .NUM_IRQ (8)
    , .IRQ_MASK(8'h02)
    , .IRQ_AT  (32'd100)
    , .IRQ_LEN (5)
`endif
  ) dut_a (
    .ph1      (ph1),
    .reset    (rst_s[0]),
    .memwrite (mw_s[0]),
    .dataadr  (adr_s[0]),
    .writedata(dat_s[0]),
    .done     (done_s[0]),
    .pass     (pass_s[0]),
    .fail     (fail_s[0]),
    .fail_code(code_s[0]),
    .match_cnt(cnt_s[0]),
    .end_cycle(end_s[0])
`ifdef MEM_WRITE_CHECKER_IRQ_STIM_EN
    , .interrupts(irq_a)
`endif
  );

  mem_write_checker #(
    .NUM_EXP (2),
    .EXP_DATA({32'd9, 32'd5}),
    .EXP_ADDR({32'h58, 32'h54}),
    .ADDR_CHK(1),
    .ORDERED (1),
    .TIMEOUT (50)
  ) dut_b (
    .ph1      (ph1),
    .reset    (rst_s[1]),
    .memwrite (mw_s[1]),
    .dataadr  (adr_s[1]),
    .writedata(dat_s[1]),
    .done     (done_s[1]),
    .pass     (pass_s[1]),
    .fail     (fail_s[1]),
    .fail_code(code_s[1]),
    .match_cnt(cnt_s[1]),
    .end_cycle(end_s[1])
  );

  mem_write_checker #(
    .NUM_EXP (3),
    .EXP_DATA({32'hC, 32'hB, 32'hA}),
    .EXP_ADDR({32'h18, 32'h14, 32'h10}),
    .ADDR_CHK(1),
    .ORDERED (0),
    .TIMEOUT (5000)
  ) dut_c (
    .ph1      (ph1),
    .reset    (rst_s[2]),
    .memwrite (mw_s[2]),
    .dataadr  (adr_s[2]),
    .writedata(dat_s[2]),
    .done     (done_s[2]),
    .pass     (pass_s[2]),
    .fail     (fail_s[2]),
    .fail_code(code_s[2]),
    .match_cnt(cnt_s[2]),
    .end_cycle(end_s[2])
  );

  typedef struct {
    int          sel;
    bit          rst;
    bit          mw;
    logic [31:0] adr;
    logic [31:0] dat;
    bit          e_done;
    bit          e_pass;
    bit          e_fail;
    logic [1:0]  e_code;
    logic [4:0]  e_cnt;
    logic [31:0] e_end;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int sel, input bit rst, input bit mw,
                              input logic [31:0] adr, input logic [31:0] dat,
                              input bit ed, input bit ep, input bit ef,
                              input logic [1:0] ec, input logic [4:0] en,
                              input logic [31:0] ee);
    vec_t v;
    v.sel = sel; v.rst = rst; v.mw = mw; v.adr = adr; v.dat = dat;
    v.e_done = ed; v.e_pass = ep; v.e_fail = ef;
    v.e_code = ec; v.e_cnt = en; v.e_end = ee;
    return v;
  endfunction

  // One clock of stimulus on the selected instance; others see no write.
  task automatic drive(input int sel, input bit rst, input bit mw,
                       input logic [31:0] adr, input logic [31:0] dat);
    @(negedge ph1);
    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b0;
      mw_s[k]  = 1'b0;
    end
    rst_s[sel] = rst;
    mw_s[sel]  = mw;
    adr_s[sel] = adr;
    dat_s[sel] = dat;
    @(posedge ph1);
    #1;
  endtask

  task automatic check(input string name, input int sel,
                       input bit ed, input bit ep, input bit ef,
                       input logic [1:0] ec, input logic [4:0] en,
                       input logic [31:0] ee);
    logic [41:0] act;
    logic [41:0] req;
    act = {done_s[sel], pass_s[sel], fail_s[sel], code_s[sel], cnt_s[sel], end_s[sel]};
    req = {ed, ep, ef, ec, en, ee};
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s dut%0d done/pass/fail/code/cnt/end actual=%0d/%0d/%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d/%0d/%0d",
               name, sel, done_s[sel], pass_s[sel], fail_s[sel], code_s[sel], cnt_s[sel], end_s[sel],
               ed, ep, ef, ec, en, ee);
    end else begin
      $display("ok   %s dut%0d done=%0d pass=%0d fail=%0d code=%0d cnt=%0d end=%0d",
               name, sel, ed, ep, ef, ec, en, ee);
    end
  endtask

  task automatic idle(input int sel, input int n);
    for (int k = 0; k < n; k++) drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b1;
      mw_s[k]  = 1'b0;
      adr_s[k] = '0;
      dat_s[k] = '0;
    end
    repeat (2) @(posedge ph1);

    // Ordered instance B: out-of-order write ignored, then in-order hits.
    vecs.push_back(mk(1, 1, 0, 32'h00, 32'd0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 32'h58, 32'd9, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 32'h54, 32'd5, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 32'h00, 32'd0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 32'h58, 32'd9, 1, 1, 0, 0, 2, 3));
    vecs.push_back(mk(1, 0, 1, 32'h54, 32'd6, 1, 1, 0, 0, 2, 3));
    // B: data conflict on entry 0, then absorbing FAIL.
    vecs.push_back(mk(1, 1, 0, 32'h00, 32'd0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 32'h54, 32'd6, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 32'h54, 32'd5, 1, 0, 1, 1, 0, 0));
    // B: right data at wrong address ignored; conflict on entry 1.
    vecs.push_back(mk(1, 1, 0, 32'h00, 32'd0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 32'h60, 32'd5, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 32'h54, 32'd5, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 32'h58, 32'd7, 1, 0, 1, 1, 1, 2));
    // Unordered instance C: no strobe, then entries 2,0,2,1.
    vecs.push_back(mk(2, 1, 0, 32'h00, 32'h0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2, 0, 0, 32'h10, 32'hA, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2, 0, 1, 32'h18, 32'hC, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(2, 0, 1, 32'h10, 32'hA, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(2, 0, 1, 32'h18, 32'hC, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(2, 0, 1, 32'h14, 32'hB, 1, 1, 0, 0, 3, 4));
    // C: reset mid-run after two hits, counts restart.
    vecs.push_back(mk(2, 1, 0, 32'h00, 32'h0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2, 0, 1, 32'h10, 32'hA, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(2, 0, 1, 32'h14, 32'hB, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(2, 1, 0, 32'h00, 32'h0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2, 0, 1, 32'h10, 32'hA, 0, 0, 0, 0, 1, 0));
    // C: conflict on an already-hit entry ignored; on an unhit entry fails.
    vecs.push_back(mk(2, 0, 1, 32'h10, 32'hF, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(2, 0, 1, 32'h14, 32'hF, 1, 0, 1, 1, 1, 2));

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].rst, vecs[i].mw, vecs[i].adr, vecs[i].dat);
      check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].e_done, vecs[i].e_pass,
            vecs[i].e_fail, vecs[i].e_code, vecs[i].e_cnt, vecs[i].e_end);
    end

    // A: data-only match; 7 at cycle 10 ignored, 2201 at cycle 20 passes.
    drive(0, 1'b1, 1'b0, 32'h0, 32'd0);
    check("a_reset", 0, 0, 0, 0, 0, 0, 0);
    idle(0, 10);
    drive(0, 1'b0, 1'b1, 32'h100, 32'd7);
    check("a_wrong_data", 0, 0, 0, 0, 0, 0, 0);
    idle(0, 9);
    drive(0, 1'b0, 1'b1, 32'h1234, 32'd2201);
    check("a_pass", 0, 1, 1, 0, 0, 1, 20);
    idle(0, 1);
    check("a_hold", 0, 1, 1, 0, 0, 1, 20);

    // B: timeout with no writes ends at cycle 49 and stays there.
    drive(1, 1'b1, 1'b0, 32'h0, 32'd0);
    idle(1, 49);
    check("b_pre_timeout", 1, 0, 0, 0, 0, 0, 0);
    idle(1, 1);
    check("b_timeout", 1, 1, 0, 1, 2, 0, 49);
    idle(1, 1);
    check("b_timeout_hold", 1, 1, 0, 1, 2, 0, 49);

    // B: final hit on the timeout cycle wins.
    drive(1, 1'b1, 1'b0, 32'h0, 32'd0);
    drive(1, 1'b0, 1'b1, 32'h54, 32'd5);
    idle(1, 48);
    check("b_pre_last", 1, 0, 0, 0, 0, 1, 0);
    drive(1, 1'b0, 1'b1, 32'h58, 32'd9);
    check("b_pass_at_timeout", 1, 1, 1, 0, 0, 2, 49);

`ifdef MEM_WRITE_CHECKER_IRQ_STIM_EN
    // A: interrupts equal 8'h02 exactly while the cycle count is 100..104.
    drive(0, 1'b1, 1'b0, 32'h0, 32'd0);
    for (int c = 0; c < 110; c++) begin
      logic [7:0] exp_irq;
      drive(0, 1'b0, 1'b0, 32'h0, 32'd0);
      exp_irq = ((c + 1) >= 100 && (c + 1) < 105) ? 8'h02 : 8'h00;
      checks++;
      if (irq_a !== exp_irq) begin
        failures++;
        $display("FAIL irq cycle=%0d actual=%02h required=%02h", c + 1, irq_a, exp_irq);
      end else begin
        $display("ok   irq cycle=%0d interrupts=%02h", c + 1, exp_irq);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable, parametrised pass/fail monitor for CPU system simulation and FPGA self-test.
- Snoops the core's data-memory write port (memwrite/dataadr/writedata) and compares writes against a sequence of NUM_EXP expected address/data pairs.
- Checks in ordered or unordered mode, with a cycle-count timeout.
- Reports done/pass/fail, a fail code, match count and end cycle. Sits beside the top-level system, outside the core.

Parameters:
- DATA_W, 32, writedata width
- ADDR_W, 32, dataadr width
- NUM_EXP, 4, number of expected writes (1..16)
- EXP_DATA, 0, flattened NUM_EXP*DATA_W vector; entry i is bits [i*DATA_W +: DATA_W]
- EXP_ADDR, 0, flattened NUM_EXP*ADDR_W vector, same layout
- ADDR_CHK, 1, 1 = match address and data; 0 = match data only
- ORDERED, 1, 1 = entries must be hit in index order; 0 = any order
- TIMEOUT, 5000, cycles in RUN before a timeout failure
- CNT_W, 32, cycle counter width
- NUM_IRQ, 8, interrupt stimulus width (optional feature only)

Ports:
- ph1  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- memwrite  in  1  write strobe, sampled at the ph1 edge
- dataadr  in  ADDR_W  write address
- writedata  in  DATA_W  write data
- done  out  1  checker reached a terminal state
- pass  out  1  all expected writes seen
- fail  out  1  mismatch or timeout
- fail_code  out  2  0 none, 1 data mismatch, 2 timeout
- match_cnt  out  5  number of entries hit so far
- end_cycle  out  CNT_W  cycle count latched on entering a terminal state
- interrupts  out  NUM_IRQ  stimulus pulses (present only with the optional feature)

Behaviour:
- Reset: state=RUN, cycle=0, hit vector=0, idx=0, all outputs 0. Reset has priority and fully clears state mid-run or from a terminal state.
- States: RUN, PASS, FAIL. PASS and FAIL are absorbing until reset.
- Cycle counter: increments every cycle in RUN and saturates at all-ones.
- Outputs are registered. A qualifying write at edge N is reflected at edge N+1.
- A write is a "hit" on entry i if writedata==EXP_DATA[i] and, when ADDR_CHK=1, dataadr==EXP_ADDR[i].
- A write is a "conflict" on entry i if ADDR_CHK=1, dataadr==EXP_ADDR[i] and writedata!=EXP_DATA[i].
- ORDERED=1:
  - Only entry idx is considered.
  - Hit: idx++, match_cnt++.
  - Conflict: go to FAIL, fail_code=1.
  - Any other write is ignored.
- ORDERED=0:
  - Only unhit entries are considered.
  - A hit sets the lowest-index matching unhit bit; match_cnt++.
  - A conflict on an unhit entry with no hit among unhit entries goes to FAIL, fail_code=1.
  - Repeat writes to already-hit entries are ignored.
- ADDR_CHK=0: conflicts cannot occur; non-matching writes are ignored.
- match_cnt reaching NUM_EXP: go to PASS.
- cycle==TIMEOUT-1 in RUN with no pass: go to FAIL, fail_code=2.
- Final hit and timeout on the same cycle: PASS wins.
- On entry to PASS or FAIL: done=1, pass or fail=1, end_cycle=cycle value at that edge.
- memwrite is ignored in terminal states.
- memwrite with X or Z: treated as 0 in synthesis; the bench must not drive X after reset.

Optional Feature:
- Macro: MEM_WRITE_CHECKER_IRQ_STIM_EN.
- When defined, adds output interrupts and parameters IRQ_MASK (NUM_IRQ bits), IRQ_AT (CNT_W, default 100) and IRQ_LEN (default 5).
- While in RUN and IRQ_AT <= cycle < IRQ_AT+IRQ_LEN, interrupts=IRQ_MASK; otherwise 0.
- interrupts is forced to 0 on reset and in terminal states.
- When undefined, the port and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package mem_checker_pkg holds:
  - state encoding: RUN=2'd0, PASS=2'd1, FAIL=2'd2
  - fail codes: FC_NONE=0, FC_DATA=1, FC_TIMEOUT=2
  - MAX_EXP=16
- One sub-module, exp_entry_match: combinational per-entry hit/conflict compare, instantiated NUM_EXP times via generate.

Test Plan:
- NUM_EXP=1, EXP_DATA=2201, ADDR_CHK=0. Write data 7 at cycle 10, then 2201 at cycle 20 -> pass=1, fail_code=0, end_cycle=20 at cycle 21.
- ORDERED=1, entries (0x54,5),(0x58,9). Write (0x58,9) then (0x54,5) -> no pass (out-of-order write ignored, idx stays 0 until (0x54,5)). A following (0x58,9) -> pass, match_cnt=2.
- ADDR_CHK=1. Write (0x54,6) against expected (0x54,5) -> fail=1, fail_code=1, done=1.
- TIMEOUT=50, no writes -> fail_code=2, end_cycle=49. Final hit injected at cycle 49 -> pass instead.
- ORDERED=0, 3 entries written in order 2,0,2,1 -> pass after the 4th write, match_cnt=3. Reset asserted mid-run after 2 hits -> all outputs 0, counts restart.
- With MEM_WRITE_CHECKER_IRQ_STIM_EN, IRQ_MASK=8'h02, IRQ_AT=100, IRQ_LEN=5 -> interrupts=8'h02 for cycles 100..104, 0 otherwise.
